// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//
// Purpose:
//   Shared definitions for the sprite display command path: the layout of a
//   32-bit command word, the well-known action codes, the scheduler state
//   type and a helper that stamps the back-buffer index into a command word.
//
// Contents:
//   CMD_*_LSB / CMD_*_W  field positions and widths inside a command word
//   ACTION_*             action codes (NOP, WRITE, SWAP)
//   sched_state_t        frame_cmd_scheduler FSM states
//   cmd_word_t           packed view of a command word
//   stamp_toggle()       returns a word with one bit forced to a given value
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int CMD_W = 32;

    localparam int CMD_COMPONENT_LSB   = 26;
    localparam int CMD_COMPONENT_W     = 6;
    localparam int CMD_CHILD_LSB       = 21;
    localparam int CMD_CHILD_W         = 5;
    localparam int CMD_ACTION_LSB      = 17;
    localparam int CMD_ACTION_W        = 4;
    localparam int CMD_ACTION_TYPE_LSB = 14;
    localparam int CMD_ACTION_TYPE_W   = 3;
    localparam int CMD_TOGGLE_BIT      = 13;
    localparam int CMD_DATA_LSB        = 0;
    localparam int CMD_DATA_W          = 13;

    localparam logic [CMD_ACTION_W-1:0] ACTION_NOP   = 4'h0;
    localparam logic [CMD_ACTION_W-1:0] ACTION_WRITE = 4'h1;
    localparam logic [CMD_ACTION_W-1:0] ACTION_SWAP  = 4'hF;

    typedef enum logic [0:0] {
        DRAIN       = 1'b0,
        WAIT_VBLANK = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [CMD_COMPONENT_W-1:0]   component;
        logic [CMD_CHILD_W-1:0]       child;
        logic [CMD_ACTION_W-1:0]      action;
        logic [CMD_ACTION_TYPE_W-1:0] action_type;
        logic                         buffer_toggle;
        logic [CMD_DATA_W-1:0]        data;
    } cmd_word_t;

    // Mask-and-or rather than a variable bit select so the position can be
    // any elaboration-time integer without index-width mismatches.
    function automatic logic [CMD_W-1:0] stamp_toggle(
        input logic [CMD_W-1:0] word,
        input int               pos,
        input logic             value
    );
        logic [CMD_W-1:0] one_hot;
        logic [CMD_W-1:0] value_bit;
        one_hot   = {{(CMD_W-1){1'b0}}, 1'b1} << pos;
        value_bit = {{(CMD_W-1){1'b0}}, value} << pos;
        return (word & ~one_hot) | value_bit;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
//
// Purpose:
//   Synchronous show-ahead FIFO holding software command words until the
//   scheduler issues them. The head entry is always visible on dout, so the
//   scheduler can inspect a word before deciding whether to pop it.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset (flushes pointers)
//   push, din    write request and data; a push into a full FIFO is only
//                taken when a pop happens in the same cycle
//   pop          remove the head entry (ignored when empty)
//   dout         current head entry (undefined content when empty)
//   full, empty  occupancy flags
//   level        current number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are told apart by
    // the difference alone.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO can still accept a word when the head leaves that cycle.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + (push_ok ? (AW + 1)'(1) : '0);
        rd_ptr_d = rd_ptr_q + (pop_ok  ? (AW + 1)'(1) : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/frame_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// frame_cmd_scheduler
//
// Purpose:
//   Buffers software command words and issues at most one per clock onto the
//   shared writedata bus feeding every sprite display component. Each issued
//   word carries the current back-buffer index in its toggle bit. A commit
//   word (action SWAP) is held until the start of vertical blank and then
//   issued as the single swap word that flips the ping/pong buffers, so a
//   flip never tears a frame. Words queued behind a commit belong to the
//   next frame and wait for the swap.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   avs_write         Avalon write strobe
//   avs_writedata     command word from software
//   avs_waitrequest   stalls the write while the FIFO is full
//   hcount, vcount    current VGA pixel column / line
//   writedata         registered command bus, zero (NOP) when idle
//   front_buf         buffer index currently being displayed
//   commit_pending    a commit reached the head and waits for vblank
//   fifo_level        current FIFO occupancy
//   missed_frames     saturating count of vblank starts passed while waiting
// -----------------------------------------------------------------------------
module frame_cmd_scheduler
    import display_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [9:0] VBLANK_LINE = 10'd480,
    parameter int         ACTION_LSB  = CMD_ACTION_LSB,
    parameter int         TOGGLE_BIT  = CMD_TOGGLE_BIT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          avs_write,
    input  logic [CMD_W-1:0]              avs_writedata,
    output logic                          avs_waitrequest,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    output logic [CMD_W-1:0]              writedata,
    output logic                          front_buf,
    output logic                          commit_pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    missed_frames
);

    sched_state_t             state_q, state_d;
    logic [CMD_W-1:0]         writedata_q, writedata_d;
    logic                     front_buf_q, front_buf_d;
    logic                     commit_pending_q, commit_pending_d;
    logic [7:0]               missed_frames_q, missed_frames_d;
    logic [9:0]               vcount_prev_q, vcount_prev_d;

    logic [CMD_W-1:0]         fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     head_is_swap;
    logic                     vblank_start;
    logic                     unused_hcount;

    // Scheduling is decided per line only; the column is part of the bus
    // interface but plays no role here.
    assign unused_hcount = ^hcount;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (avs_writedata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign head_is_swap = (fifo_dout[ACTION_LSB +: CMD_ACTION_W] == ACTION_SWAP);

    // Rising into the blank line: a line already at VBLANK_LINE out of reset
    // does not count, because the previous line resets to VBLANK_LINE.
    assign vblank_start = (vcount == VBLANK_LINE) && (vcount_prev_q != VBLANK_LINE);

    // A full FIFO releases the master in the cycle the head is popped, so the
    // stalled word is taken on the same edge the slot frees up.
    assign avs_waitrequest = fifo_full && !fifo_pop;
    assign fifo_push       = avs_write && !avs_waitrequest;

    assign writedata       = writedata_q;
    assign front_buf       = front_buf_q;
    assign commit_pending  = commit_pending_q;
    assign missed_frames   = missed_frames_q;

    // Next-state and issue logic. writedata defaults to NOP so every issued
    // command is a single-cycle pulse.
    always_comb begin
        state_d          = state_q;
        writedata_d      = '0;
        front_buf_d      = front_buf_q;
        commit_pending_d = commit_pending_q;
        missed_frames_d  = missed_frames_q;
        vcount_prev_d    = vcount;
        fifo_pop         = 1'b0;

        case (state_q)
            DRAIN: begin
                if (!fifo_empty) begin
                    if (head_is_swap) begin
                        commit_pending_d = 1'b1;
                        state_d          = WAIT_VBLANK;
                    end else begin
                        fifo_pop    = 1'b1;
                        writedata_d = stamp_toggle(fifo_dout, TOGGLE_BIT, ~front_buf_q);
                    end
                end
            end

            WAIT_VBLANK: begin
                if (vblank_start && !fifo_empty) begin
                    fifo_pop         = 1'b1;
                    writedata_d      = stamp_toggle(fifo_dout, TOGGLE_BIT, ~front_buf_q);
                    front_buf_d      = ~front_buf_q;
                    commit_pending_d = 1'b0;
                    state_d          = DRAIN;
                end else if (vblank_start && (missed_frames_q != 8'hFF)) begin
                    // Only reachable once a deadline mode lets a blank pass
                    // without swapping; the first blank always swaps today.
                    missed_frames_d = missed_frames_q + 8'd1;
                end
            end

            default: begin
                state_d = DRAIN;
            end
        endcase
    end

    // State register; reset drops any pending commit and returns to buffer 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= DRAIN;
            writedata_q      <= '0;
            front_buf_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            missed_frames_q  <= '0;
            vcount_prev_q    <= VBLANK_LINE;
        end else begin
            state_q          <= state_d;
            writedata_q      <= writedata_d;
            front_buf_q      <= front_buf_d;
            commit_pending_q <= commit_pending_d;
            missed_frames_q  <= missed_frames_d;
            vcount_prev_q    <= vcount_prev_d;
        end
    end

endmodule
